fir_reload_axil_slave: RTL and testbench

AXI4-Lite slave register block for the FIR_reloadable IP. It is the responder to the S00_AXI master port.
- Holds NUM_COEF coefficient registers plus control/status registers.
- On a software reload command, streams the coefficients to the FIR core over a valid/ready coefficient channel.
- Sits between the PS AXI interconnect and the FIR datapath.

---
 rtl/fir_reload_pkg.sv | 35 +++
 rtl/fir_reload_axil_slave_streamer.sv | 96 +++++++++
 rtl/fir_reload_axil_slave.sv | 196 +++++++++++++++++++
 tb/tb_fir_reload_axil_slave.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_reload_pkg.sv
// Shared definitions for the FIR reload AXI4-Lite register block.
// Contents: register byte offsets, AXI response codes, the reload FSM state
// type and a byte-strobe merge helper used for register writes.
package fir_reload_pkg;

    localparam logic [4:0] COEF_BASE   = 5'h00;
    localparam logic [4:0] CTRL_OFF    = 5'h10;
    localparam logic [4:0] STATUS_OFF  = 5'h14;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } reload_state_t;

    // Merge new_v into old_v one byte lane at a time, lanes chosen by strb.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_reload_axil_slave_streamer.sv
// fir_coef_streamer: streams a coefficient vector to the FIR core over a
// valid/ready channel when start_i pulses in IDLE.
// Ports: clk_i/rst_i (async active-high), start_i, coef_i (flat vector,
// coef k at bits [32k+31:32k]), tready_i, tdata_o/tvalid_o/tlast_o,
// busy_o (stream in progress), done_o (one-cycle pulse in DONE),
// count_o (completed reloads, wraps at 255).
module fir_coef_streamer
    import fir_reload_pkg::*;
#(
    parameter int NUM_COEF = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [NUM_COEF*32-1:0] coef_i,
    input  logic                  tready_i,
    output logic [31:0]           tdata_o,
    output logic                  tvalid_o,
    output logic                  tlast_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [7:0]            count_o
);

    localparam int IDX_W = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEF - 1);

    reload_state_t    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic [7:0]       count_q, count_d;

    // State, beat index, busy flag and reload counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    // Next-state logic for the reload sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = STREAM;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (tready_i) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        state_d = STREAM;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                count_d = count_q + 8'd1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Outputs decode straight from registers so an async reset drops tvalid at once.
    assign tvalid_o = (state_q == STREAM);
    assign tdata_o  = tvalid_o ? coef_i[{idx_q, 5'b00000} +: 32] : 32'h0000_0000;
    assign tlast_o  = tvalid_o && (idx_q == LAST_IDX);
    assign busy_o   = busy_q;
    assign done_o   = (state_q == DONE);
    assign count_o  = count_q;

endmodule

// File: rtl/fir_reload_axil_slave.sv
// fir_reload_axil_slave: AXI4-Lite register block for the reloadable FIR.
// Holds NUM_COEF coefficient registers, CTRL (bit0 reload, bit1 done-clear)
// and STATUS ({reload_count, done, busy}); a reload streams the coefficients
// to the FIR core on coef_*.
// Ports: s00_axi_* AXI4-Lite slave (async active-high s00_axi_areset),
// coef_tdata/tvalid/tready/tlast coefficient stream, reload_busy.
module fir_reload_axil_slave
    import fir_reload_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_COEF           = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [31:0]                     coef_tdata,
    output logic                            coef_tvalid,
    input  logic                            coef_tready,
    output logic                            coef_tlast,
    output logic                            reload_busy
);

    logic                   awready_q, wready_q, aw_held_q, w_held_q;
    logic                   bvalid_q, arready_q, rvalid_q, done_q;
    logic [2:0]             awidx_q;
    logic [31:0]            wdata_q, rdata_q;
    logic [3:0]             wstrb_q;
    logic [1:0]             bresp_q;
    logic [NUM_COEF*32-1:0] coef_q;

    logic        aw_hs_s, w_hs_s, ar_hs_s, wr_fire_s;
    logic        wr_is_coef_s, wr_is_ctrl_s, coef_we_s;
    logic        start_s, done_clr_s, done_set_s, busy_s;
    logic [2:0]  wr_idx_s, rd_idx_s;
    logic [31:0] wr_data_s, rd_mux_s;
    logic [3:0]  wr_strb_s;
    logic [7:0]  count_s;
    logic        unused_s;

    assign aw_hs_s = s00_axi_awvalid & awready_q;
    assign w_hs_s  = s00_axi_wvalid & wready_q;
    assign ar_hs_s = s00_axi_arvalid & arready_q;

    // A write commits as soon as both halves are present, whether latched earlier or arriving now.
    assign wr_fire_s = (aw_held_q | aw_hs_s) & (w_held_q | w_hs_s) & ~bvalid_q;
    assign wr_idx_s  = aw_hs_s ? s00_axi_awaddr[4:2] : awidx_q;
    assign wr_data_s = w_hs_s ? s00_axi_wdata : wdata_q;
    assign wr_strb_s = w_hs_s ? s00_axi_wstrb : wstrb_q;

    assign wr_is_coef_s = (int'(wr_idx_s) < NUM_COEF);
    assign wr_is_ctrl_s = (wr_idx_s == CTRL_OFF[4:2]);
    assign coef_we_s    = wr_fire_s & wr_is_coef_s & ~busy_s;
    // CTRL bits live in byte lane 0; the streamer ignores start unless IDLE.
    assign start_s      = wr_fire_s & wr_is_ctrl_s & wr_strb_s[0] & wr_data_s[0];
    assign done_clr_s   = wr_fire_s & wr_is_ctrl_s & wr_strb_s[0] & wr_data_s[1];

    assign rd_idx_s = s00_axi_araddr[4:2];
    assign unused_s = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // Write address/data acceptance, latching and write response.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awidx_q   <= 3'd0;
            wdata_q   <= 32'h0000_0000;
            wstrb_q   <= 4'h0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            awready_q <= s00_axi_awvalid & ~awready_q & ~aw_held_q & ~bvalid_q;
            wready_q  <= s00_axi_wvalid & ~wready_q & ~w_held_q & ~bvalid_q;
            if (wr_fire_s) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= (wr_is_coef_s & busy_s) ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (aw_hs_s) begin
                    aw_held_q <= 1'b1;
                    awidx_q   <= s00_axi_awaddr[4:2];
                end
                if (w_hs_s) begin
                    w_held_q <= 1'b1;
                    wdata_q  <= s00_axi_wdata;
                    wstrb_q  <= s00_axi_wstrb;
                end
                if (bvalid_q & s00_axi_bready) begin
                    bvalid_q <= 1'b0;
                end
            end
        end
    end

    // Coefficient storage; writes are dropped while a reload is streaming.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            coef_q <= '0;
        end else if (coef_we_s) begin
            for (int k = 0; k < NUM_COEF; k++) begin
                if (int'(wr_idx_s) == k) begin
                    coef_q[32*k +: 32] <= apply_wstrb(coef_q[32*k +: 32], wr_data_s, wr_strb_s);
                end
            end
        end
    end

    // Sticky done flag; a completion in the same cycle as a clear wins.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            done_q <= 1'b0;
        end else if (done_set_s) begin
            done_q <= 1'b1;
        end else if (done_clr_s) begin
            done_q <= 1'b0;
        end
    end

    // Read data mux; sampled from current registers, so a same-cycle write is not visible.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        if (int'(rd_idx_s) < NUM_COEF) begin
            rd_mux_s = coef_q[{rd_idx_s[1:0], 5'b00000} +: 32];
        end else if (rd_idx_s == STATUS_OFF[4:2]) begin
            rd_mux_s = {16'h0000, count_s, 6'b000000, done_q, busy_s};
        end else begin
            rd_mux_s = 32'h0000_0000;
        end
    end

    // Read address acceptance and registered read response.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0000_0000;
        end else begin
            arready_q <= s00_axi_arvalid & ~arready_q & ~rvalid_q;
            if (ar_hs_s) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux_s;
            end else if (rvalid_q & s00_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    fir_coef_streamer #(
        .NUM_COEF (NUM_COEF)
    ) u_streamer (
        .clk_i    (s00_axi_aclk),
        .rst_i    (s00_axi_areset),
        .start_i  (start_s),
        .coef_i   (coef_q),
        .tready_i (coef_tready),
        .tdata_o  (coef_tdata),
        .tvalid_o (coef_tvalid),
        .tlast_o  (coef_tlast),
        .busy_o   (busy_s),
        .done_o   (done_set_s),
        .count_o  (count_s)
    );

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = RESP_OKAY;
    assign reload_busy     = busy_s;

endmodule

// File: tb/tb_fir_reload_axil_slave.sv
// Self-checking bench for fir_reload_axil_slave: directed register-map,
// reload-stream, busy-write and reset scenarios followed by randomized
// register traffic, all compared against a behavioural register model.
module tb_fir_reload_axil_slave;

    localparam int NUM_COEF = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata, coef_tdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        coef_tvalid, coef_tready, coef_tlast, reload_busy;

    int errors = 0;
    int checks = 0;
    int tready_mode = 0;
    int beats_seen = 0;

    // behavioural model state
    logic [31:0] coef_m [NUM_COEF];
    logic        done_m, busy_m;
    logic [7:0]  cnt_m;
    logic [31:0] exp_q [$];
    logic        stall_prev = 1'b0;
    logic [31:0] stall_data = 32'h0;

    fir_reload_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .NUM_COEF           (NUM_COEF)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (rst),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .coef_tdata      (coef_tdata),
        .coef_tvalid     (coef_tvalid),
        .coef_tready     (coef_tready),
        .coef_tlast      (coef_tlast),
        .reload_busy     (reload_busy)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // coef_tready pattern: 0 hold low, 1 hold high, 2 toggle, else random
    initial begin
        coef_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                0:       coef_tready = 1'b0;
                1:       coef_tready = 1'b1;
                2:       coef_tready = ~coef_tready;
                default: coef_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // negedge half of a cycle: stream monitor runs here
    task automatic mon_neg();
        @(negedge clk);
        if (!rst) begin
            if (stall_prev) begin
                check_val("stall_valid", {31'b0, coef_tvalid}, 32'd1);
                check_val("stall_data", coef_tdata, stall_data);
            end
            if (coef_tvalid && coef_tready) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_beat", {31'b0, coef_tvalid}, 32'd0);
                end else begin
                    check_val("beat_data", coef_tdata, exp_q[0]);
                    check_val("beat_last", {31'b0, coef_tlast}, {31'b0, (exp_q.size() == 1)});
                    void'(exp_q.pop_front());
                end
                beats_seen++;
            end
            stall_prev = coef_tvalid && !coef_tready;
            stall_data = coef_tdata;
        end else begin
            stall_prev = 1'b0;
        end
    endtask

    task automatic mon_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        mon_neg();
        mon_pos();
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int lat);
        int  n;
        logic a_hs, w_hs;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 40) begin
            mon_neg();
            a_hs = awvalid && awready;
            w_hs = wvalid && wready;
            mon_pos();
            if (a_hs) awvalid = 1'b0;
            if (w_hs) wvalid = 1'b0;
            n++;
        end
        if (awvalid || wvalid) check_val("aw_w_timeout", {30'b0, awvalid, wvalid}, 32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        lat = n;
        n = 0;
        while (!bvalid && n < 40) begin
            cycle();
            n++;
        end
        if (!bvalid) check_val("b_timeout", {31'b0, bvalid}, 32'd1);
        lat = lat + n;
        resp = bresp;
        bready = 1'b1;
        cycle();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        int  n;
        logic hs;
        araddr = a;
        arvalid = 1'b1;
        n = 0;
        while (arvalid && n < 40) begin
            mon_neg();
            hs = arvalid && arready;
            mon_pos();
            if (hs) arvalid = 1'b0;
            n++;
        end
        if (arvalid) check_val("ar_timeout", {31'b0, arvalid}, 32'd0);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 40) begin
            cycle();
            n++;
        end
        if (!rvalid) check_val("r_timeout", {31'b0, rvalid}, 32'd1);
        d = rdata;
        resp = rresp;
        rready = 1'b1;
        cycle();
        rready = 1'b0;
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        int w;
        w = int'(a[4:2]);
        if (w < NUM_COEF) return coef_m[w];
        if (w == 5) return {16'h0, cnt_m, 6'h0, done_m, busy_m};
        return 32'h0;
    endfunction

    // Apply a register write to the model; queues the expected stream on a reload.
    task automatic model_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        int w;
        logic [31:0] mask;
        w = int'(a[4:2]);
        resp = 2'b00;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (w < NUM_COEF) begin
            if (busy_m) resp = 2'b10;
            else coef_m[w] = (coef_m[w] & ~mask) | (d & mask);
        end else if (w == 4 && s[0]) begin
            if (d[1]) done_m = 1'b0;
            if (d[0] && !busy_m) begin
                busy_m = 1'b1;
                for (int k = 0; k < NUM_COEF; k++) exp_q.push_back(coef_m[k]);
            end
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] er, gr;
        int lat;
        model_wr(a, d, s, er);
        axi_write(a, d, s, gr, lat);
        check_val("bresp", {30'b0, gr}, {30'b0, er});
    endtask

    task automatic do_read(input logic [4:0] a, output logic [31:0] d);
        logic [1:0] r;
        axi_read(a, d, r);
        check_val("rdata", d, model_rd(a));
        check_val("rresp", {30'b0, r}, 32'd0);
    endtask

    task automatic wait_reload();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || reload_busy) && n < 500) begin
            cycle();
            n++;
        end
        check_val("stream_left", exp_q.size(), 32'd0);
        check_val("busy_clear", {31'b0, reload_busy}, 32'd0);
        busy_m = 1'b0;
        done_m = 1'b1;
        cnt_m  = cnt_m + 8'd1;
    endtask

    initial begin
        logic [31:0] rd, pre;
        logic [1:0]  r, er;
        int          lat, b0, n;
        logic [4:0]  a;

        rst = 1'b1;
        awaddr = 5'd0; araddr = 5'd0; awprot = 3'd0; arprot = 3'd0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = 32'h0; wstrb = 4'h0;
        for (int k = 0; k < NUM_COEF; k++) coef_m[k] = 32'h0;
        done_m = 1'b0; busy_m = 1'b0; cnt_m = 8'd0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready", {29'b0, awready, wready, arready}, 32'd0);
        check_val("rst_valid", {30'b0, bvalid, rvalid}, 32'd0);
        check_val("rst_coef", {coef_tdata[29:0], coef_tvalid, coef_tlast}, 32'd0);
        check_val("rst_busy", {31'b0, reload_busy}, 32'd0);
        check_val("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        cycle();

        // basic write/read-back with first-write latency
        model_wr(5'h00, 32'd1, 4'hF, er);
        axi_write(5'h00, 32'd1, 4'hF, r, lat);
        check_val("bresp", {30'b0, r}, {30'b0, er});
        check_val("wr_latency", lat, 32'd2);
        for (int k = 1; k < NUM_COEF; k++) do_write(5'(4*k), 32'(k + 1), 4'hF);
        for (int k = 0; k < NUM_COEF; k++) do_read(5'(4*k), rd);

        // byte strobes
        do_write(5'h04, 32'h0, 4'hF);
        do_write(5'h04, 32'hAABBCCDD, 4'b0101);
        do_read(5'h04, rd);
        check_val("strobe_word", rd, 32'h00BB00DD);
        do_write(5'h04, 32'd2, 4'hF);

        // reload with toggling tready
        tready_mode = 2;
        do_write(5'h10, 32'd1, 4'hF);
        wait_reload();
        do_read(5'h14, rd);
        check_val("status_after_reload", rd, 32'h00000102);

        // coefficient write and reload request while streaming is stalled
        tready_mode = 0;
        do_write(5'h10, 32'd1, 4'hF);
        repeat (3) cycle();
        do_write(5'h00, 32'h99, 4'hF);
        do_write(5'h10, 32'd1, 4'hF);
        do_read(5'h00, rd);
        check_val("coef0_kept", rd, 32'd1);
        tready_mode = 1;
        wait_reload();
        do_read(5'h14, rd);

        // read and write of the same register at the same time
        pre = model_rd(5'h08);
        model_wr(5'h08, 32'h55, 4'hF, er);
        fork
            axi_write(5'h08, 32'h55, 4'hF, r, lat);
            axi_read(5'h08, rd, er);
        join
        check_val("same_cycle_rd", rd, pre);
        check_val("same_cycle_bresp", {30'b0, r}, 32'd0);
        do_read(5'h08, rd);

        // unmapped offsets
        do_read(5'h18, rd);
        do_write(5'h1C, 32'hFFFFFFFF, 4'hF);
        for (int k = 0; k < 6; k++) do_read(5'(4*k), rd);

        // randomized register traffic with random backpressure
        tready_mode = 3;
        for (int i = 0; i < 60; i++) begin
            a = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, $urandom, 4'($urandom_range(0, 15)));
                if (busy_m) wait_reload();
            end else begin
                do_read(a, rd);
            end
        end

        // reset in the middle of a stream
        tready_mode = 2;
        do_write(5'h10, 32'd1, 4'hF);
        b0 = beats_seen;
        n = 0;
        while (beats_seen < b0 + 2 && n < 100) begin
            cycle();
            n++;
        end
        check_val("two_beats", beats_seen - b0, 32'd2);
        #1;
        rst = 1'b1;
        #1;
        check_val("rst_tvalid", {31'b0, coef_tvalid}, 32'd0);
        check_val("rst_busy_mid", {31'b0, reload_busy}, 32'd0);
        cycle();
        cycle();
        rst = 1'b0;
        exp_q.delete();
        for (int k = 0; k < NUM_COEF; k++) coef_m[k] = 32'h0;
        done_m = 1'b0; busy_m = 1'b0; cnt_m = 8'd0;
        cycle();
        for (int k = 0; k < 6; k++) do_read(5'(4*k), rd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
